// File: rtl/pe_row_cfg_sched.sv
// pe_row_cfg_sched
//   Configuration and run sequencer for one PE row (the LSU plus PE_0..PE_3).
//   Accepts tagged configuration words over a valid/ready stream. Each accepted
//   word produces a one-cycle load pulse on the shared PE_config bus, with a
//   one-hot init_sel naming the target. Once all five targets hold a
//   configuration, the row runs for the latched number of cycles and then
//   reports done.
//
//   Optional build macro: PE_ROW_CFG_BCAST_EN
//     When defined, cfg_tgt==7 broadcasts one word to PE_0..PE_3 in a single
//     pulse (init_sel=5'b01111). When undefined, tgt 7 is an error like tgt 5
//     and tgt 6.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   start      begin a load/run sequence; sampled only in IDLE
//   run_len    run cycles, latched when start is accepted (0 is an error)
//   cfg_valid  config word valid
//   cfg_ready  config word accepted on cfg_valid & cfg_ready (LOAD only)
//   cfg_tgt    0=LSU, 1..4=PE_0..PE_3
//   cfg_data   config word
//   PE_config  registered config word to the row; holds its last value
//   init_en    one-cycle load strobe
//   init_sel   one-hot target: bit4=LSU, bit3=PE_0 .. bit0=PE_3
//   run        row run enable
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   err        sticky error; cleared by the next accepted start
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting config words until all five targets are loaded
// ARM   | final load pulse visible; one cycle
// RUN   | run high for run_len cycles
// DONE  | done pulse; one cycle
module pe_row_cfg_sched #(
  parameter int PE_INST_W = 64,
  parameter int RUN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RUN_CNT_W-1:0] run_len,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2:0]           cfg_tgt,
  input  logic [PE_INST_W-1:0] cfg_data,
  output logic [PE_INST_W-1:0] PE_config,
  output logic                 init_en,
  output logic [4:0]           init_sel,
  output logic                 run,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [4:0]           mask_q, mask_d;
  logic [RUN_CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_CNT_W-1:0] len_q, len_d;
  logic [PE_INST_W-1:0] cfg_q, cfg_d;
  logic                 en_q, en_d;
  logic [4:0]           sel_q, sel_d;
  logic                 err_q, err_d;

  logic                 tgt_ok;
  logic [4:0]           tgt_sel;

  // Target decode. The mask uses the same bit order as init_sel, so a
  // broadcast sets all four PE mask bits in one step.
  always_comb begin
    tgt_ok  = 1'b1;
    tgt_sel = 5'b00000;
    case (cfg_tgt)
      3'd0: tgt_sel = 5'b10000;
      3'd1: tgt_sel = 5'b01000;
      3'd2: tgt_sel = 5'b00100;
      3'd3: tgt_sel = 5'b00010;
      3'd4: tgt_sel = 5'b00001;
`ifdef PE_ROW_CFG_BCAST_EN
      3'd7: tgt_sel = 5'b01111;
`endif
      default: tgt_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cfg_d   = cfg_q;
    en_d    = 1'b0;
    sel_d   = 5'b00000;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (run_len == '0) begin
            err_d = 1'b1;
          end else begin
            len_d   = run_len;
            mask_d  = 5'b00000;
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          if (tgt_ok) begin
            en_d   = 1'b1;
            sel_d  = tgt_sel;
            cfg_d  = cfg_data;
            mask_d = mask_q | tgt_sel;
            if (&(mask_q | tgt_sel)) begin
              state_d = ARM;
            end
          end else begin
            // Bad target: word is consumed and dropped.
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        cnt_d   = len_q - RUN_CNT_W'(1);
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - RUN_CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= 5'b00000;
      cnt_q   <= '0;
      len_q   <= '0;
      cfg_q   <= '0;
      en_q    <= 1'b0;
      sel_q   <= 5'b00000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cfg_q   <= cfg_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Status outputs decode straight from the state register so that an
  // asynchronous reset removes run/busy in the same cycle.
  assign cfg_ready = (state_q == LOAD);
  assign run       = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign PE_config = cfg_q;
  assign init_en   = en_q;
  assign init_sel  = sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pe_row_cfg_sched.sv
// Testbench for pe_row_cfg_sched: directed stimulus, a cycle-level reference
// model built from the sequencing rules, and hand-computed literal checks.
module tb_pe_row_cfg_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] run_len;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_tgt;
  logic [63:0] cfg_data;
  logic [63:0] PE_config;
  logic        init_en;
  logic [4:0]  init_sel;
  logic        run;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  pe_row_cfg_sched #(.PE_INST_W(64), .RUN_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tgt(cfg_tgt),
    .cfg_data(cfg_data), .PE_config(PE_config), .init_en(init_en),
    .init_sel(init_sel), .run(run), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model. Expectations describe the cycle after each rising edge,
  // derived from the timing rules: a sequence completes its load at cycle T,
  // runs on T+2..T+1+len and signals done at T+2+len.
  int          cyc = 0;
  int          run_first = 0;
  int          run_last = 0;
  int          done_at = 0;
  int          m_len = 0;
  bit          m_seq = 0;
  bit          m_load = 0;
  bit          m_err = 0;
  bit          m_en = 0;
  bit [4:0]    m_sel = 0;
  logic [63:0] m_pe = 0;
  bit          m_loaded [5];

  always @(posedge clk) begin
    if (!rst) begin
      m_seq = 0; m_load = 0; m_err = 0; m_en = 0; m_sel = 0; m_pe = 0;
      for (int i = 0; i < 5; i++) m_loaded[i] = 0;
      cyc++;
    end else begin
      m_en  = 0;
      m_sel = 0;
      if (!m_seq) begin
        if (start) begin
          if (run_len == 0) m_err = 1;
          else begin
            m_err = 0; m_len = int'(run_len); m_seq = 1; m_load = 1;
            for (int i = 0; i < 5; i++) m_loaded[i] = 0;
          end
        end
      end else if (m_load && cfg_valid) begin
        if (cfg_tgt <= 3'd4) begin
          m_en = 1;
          m_sel = 5'(1 << (4 - int'(cfg_tgt)));
          m_pe = cfg_data;
          m_loaded[int'(cfg_tgt)] = 1;
        end
`ifdef PE_ROW_CFG_BCAST_EN
        else if (cfg_tgt == 3'd7) begin
          m_en = 1; m_sel = 5'b01111; m_pe = cfg_data;
          for (int i = 1; i < 5; i++) m_loaded[i] = 1;
        end
`endif
        else m_err = 1;
        if (m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3] && m_loaded[4]) begin
          m_load = 0;
          run_first = cyc + 2;
          run_last  = cyc + 1 + m_len;
          done_at   = cyc + 2 + m_len;
        end
      end
      cyc++;
      if (m_seq && !m_load && cyc > done_at) m_seq = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst cfg_ready", 64'(cfg_ready), 64'(0));
      chk("rst init_en", 64'(init_en), 64'(0));
      chk("rst init_sel", 64'(init_sel), 64'(0));
      chk("rst run", 64'(run), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst done", 64'(done), 64'(0));
      chk("rst err", 64'(err), 64'(0));
      chk("rst PE_config", PE_config, 64'(0));
    end else begin
      chk("cfg_ready", 64'(cfg_ready), 64'(m_load));
      chk("init_en", 64'(init_en), 64'(m_en));
      chk("init_sel", 64'(init_sel), 64'(m_sel));
      chk("PE_config", PE_config, m_pe);
      chk("run", 64'(run), 64'(m_seq && !m_load && cyc >= run_first && cyc <= run_last));
      chk("done", 64'(done), 64'(m_seq && !m_load && cyc == done_at));
      chk("busy", 64'(busy), 64'(m_seq));
      chk("err", 64'(err), 64'(m_err));
`ifndef PE_ROW_CFG_BCAST_EN
      chk("init_sel onehot", 64'($countones(init_sel) <= 1), 64'(1));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [15:0] len);
    start = 1'b1;
    run_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] tgt, input logic [63:0] data);
    cfg_valid = 1'b1;
    cfg_tgt = tgt;
    cfg_data = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; run_len = '0;
    cfg_valid = 1'b0; cfg_tgt = '0; cfg_data = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle busy", 64'(busy), 64'(0));
    chk("idle cfg_ready", 64'(cfg_ready), 64'(0));

    // Basic in-order load, run_len=3; run_len change after latching ignored.
    start_seq(16'd3);
    run_len = 16'd7;
    for (int t = 0; t < 5; t++) begin
      send(3'(t), 64'hA0 + 64'(t));
      chk("t1 init_en", 64'(init_en), 64'(1));
      chk("t1 init_sel", 64'(init_sel), 64'(5'b10000 >> t));
      chk("t1 PE_config", PE_config, 64'hA0 + 64'(t));
    end
    chk("t1 arm cfg_ready", 64'(cfg_ready), 64'(0));
    chk("t1 arm run", 64'(run), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1 run", 64'(run), 64'(1));
      chk("t1 run init_en", 64'(init_en), 64'(0));
    end
    tick();
    chk("t1 done", 64'(done), 64'(1));
    chk("t1 done run", 64'(run), 64'(0));
    tick();
    chk("t1 busy after", 64'(busy), 64'(0));
    chk("t1 PE_config hold", PE_config, 64'hA4);

    // Repeated target, plus start while busy (ignored).
    start_seq(16'd2);
    start = 1'b1;
    run_len = 16'd0;
    send(3'd2, 64'h11);
    start = 1'b0;
    chk("t2 first sel", 64'(init_sel), 64'(5'b00100));
    chk("t2 first data", PE_config, 64'h11);
    send(3'd2, 64'h22);
    chk("t2 second sel", 64'(init_sel), 64'(5'b00100));
    chk("t2 second data", PE_config, 64'h22);
    chk("t2 err", 64'(err), 64'(0));
    send(3'd0, 64'h30);
    send(3'd1, 64'h31);
    send(3'd3, 64'h33);
    chk("t2 mask incomplete", 64'(cfg_ready), 64'(1));
    send(3'd4, 64'h34);
    chk("t2 arm", 64'(cfg_ready), 64'(0));
    wait_idle(20);

    // Bad target in LOAD.
    start_seq(16'd2);
    send(3'd6, 64'hBAD);
    chk("t3 no pulse", 64'(init_en), 64'(0));
    chk("t3 err", 64'(err), 64'(1));
    chk("t3 still load", 64'(cfg_ready), 64'(1));
    for (int t = 0; t < 5; t++) send(3'(t), 64'h50 + 64'(t));
    wait_idle(20);
    chk("t3 err sticky", 64'(err), 64'(1));

    // run_len=0 error, then run_len=1 clears err and runs one cycle.
    start_seq(16'd0);
    chk("t4 len0 err", 64'(err), 64'(1));
    chk("t4 len0 busy", 64'(busy), 64'(0));
    start_seq(16'd1);
    chk("t4 err cleared", 64'(err), 64'(0));
    for (int t = 0; t < 5; t++) send(3'(t), 64'h60 + 64'(t));
    tick();
    chk("t4 run1", 64'(run), 64'(1));
    tick();
    chk("t4 run1 end", 64'(run), 64'(0));
    chk("t4 done", 64'(done), 64'(1));
    tick();

    // Asynchronous reset in the middle of RUN.
    start_seq(16'd10);
    for (int t = 0; t < 5; t++) send(3'(t), 64'h70 + 64'(t));
    tick();
    tick();
    chk("t5 running", 64'(run), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("t5 async run", 64'(run), 64'(0));
    chk("t5 async busy", 64'(busy), 64'(0));
    chk("t5 async init_en", 64'(init_en), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5 post busy", 64'(busy), 64'(0));
    chk("t5 post cfg_ready", 64'(cfg_ready), 64'(0));

    // Target 7.
    start_seq(16'd2);
    send(3'd0, 64'h80);
    chk("t6 lsu sel", 64'(init_sel), 64'(5'b10000));
    send(3'd7, 64'h87);
`ifdef PE_ROW_CFG_BCAST_EN
    chk("t6 bcast sel", 64'(init_sel), 64'(5'b01111));
    chk("t6 bcast data", PE_config, 64'h87);
    chk("t6 bcast arm", 64'(cfg_ready), 64'(0));
    tick();
    chk("t6 bcast run", 64'(run), 64'(1));
`else
    chk("t6 tgt7 no pulse", 64'(init_en), 64'(0));
    chk("t6 tgt7 err", 64'(err), 64'(1));
    for (int t = 1; t < 5; t++) send(3'(t), 64'h90 + 64'(t));
`endif
    wait_idle(20);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
